// File: rtl/even_odd_updown_pkg.sv
`default_nettype none
// ============================================================================
// Module      : even_odd_updown_pkg
// Description : Shared direction codes, step size and parity-class bound helper
//               for the even/odd up/down counter.
// Revision    : 1.0 - initial release
// ============================================================================
package even_odd_updown_pkg;

    localparam logic MODE_UP   = 1'b1;
    localparam logic MODE_DOWN = 1'b0;
    localparam int   STEP      = 2;

    // Largest (want_max=1) or smallest (want_max=0) value sharing the given LSB.
    function automatic logic [63:0] parity_bound(
        input int unsigned width,
        input logic        lsb,
        input logic        want_max
    );
        logic [63:0] all_ones;
        all_ones = (64'd1 << width) - 64'd1;
        if (want_max) begin
            return lsb ? all_ones : (all_ones - 64'd1);
        end
        return {63'd0, lsb};
    endfunction

endpackage
`default_nettype wire

// File: rtl/even_odd_updown_counter_eo_step.sv
`default_nettype none
// ============================================================================
// Module      : eo_step
// Description : Combinational +/-2 next-value unit. Wraps modulo 2^WIDTH by
//               default; saturates within the parity class when the macro
//               EOC_SATURATE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module eo_step
    import even_odd_updown_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_cur,
    input  logic             i_mode,
    output logic [WIDTH-1:0] o_next
);

`ifdef EOC_SATURATE_EN
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_limit_hi;
    logic [WIDTH-1:0] w_limit_lo;

    assign w_sum      = {1'b0, i_cur} + (WIDTH+1)'(STEP);
    assign w_diff     = {1'b0, i_cur} - (WIDTH+1)'(STEP);
    assign w_limit_hi = WIDTH'(parity_bound(WIDTH, i_cur[0], 1'b1));
    assign w_limit_lo = WIDTH'(parity_bound(WIDTH, i_cur[0], 1'b0));

    // A carry/borrow out of the extra bit means the step would leave the class range.
    always_comb begin
        o_next = i_cur;
        if (i_mode == MODE_UP) begin
            o_next = w_sum[WIDTH] ? w_limit_hi : w_sum[WIDTH-1:0];
        end else begin
            o_next = w_diff[WIDTH] ? w_limit_lo : w_diff[WIDTH-1:0];
        end
    end
`else
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;

    assign w_sum  = i_cur + WIDTH'(STEP);
    assign w_diff = i_cur - WIDTH'(STEP);

    always_comb begin
        o_next = i_cur;
        if (i_mode == MODE_UP) begin
            o_next = w_sum;
        end else begin
            o_next = w_diff;
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/even_odd_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : even_odd_updown_counter
// Description : Parity-preserving up/down counter stepping by 2 with
//               synchronous load. Optional saturation via EOC_SATURATE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module even_odd_updown_counter
    import even_odd_updown_pkg::*;
#(
    parameter int WIDTH = 4  // must be >= 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             mode,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_next;

    eo_step #(
        .WIDTH (WIDTH)
    ) u_eo_step (
        .i_cur  (r_count),
        .i_mode (mode),
        .o_next (w_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= data_in;
        end else begin
            r_count <= w_next;
        end
    end

    assign data_out = r_count;

endmodule
`default_nettype wire

// File: tb/tb_even_odd_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_even_odd_updown_counter
// Description : Directed self-checking bench for even_odd_updown_counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_even_odd_updown_counter;

    logic       clk;
    logic       rst;
    logic       load;
    logic       mode;
    logic [3:0] data_in;
    logic [3:0] data_out;

    int total = 0;
    int bad   = 0;

    even_odd_updown_counter #(
        .WIDTH (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .mode     (mode),
        .data_in  (data_in),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then compare the registered output.
    task automatic step_chk(input string tag, input logic [3:0] exp);
        @(posedge clk);
        #1;
        total++;
        assert (data_out === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, data_out, exp);
        end
    endtask

    initial begin
        rst     = 1'b1;
        load    = 1'b0;
        mode    = 1'b1;
        data_in = 4'd0;
        step_chk("reset", 4'd0);

        // Count down from reset value.
        rst  = 1'b0;
        mode = 1'b0;
        step_chk("rst_dn0", 4'd14);
        step_chk("rst_dn1", 4'd12);
        step_chk("rst_dn2", 4'd10);

        // Reset mid-count.
        rst = 1'b1;
        step_chk("rst_mid", 4'd0);
        rst = 1'b0;

`ifndef EOC_SATURATE_EN
        // Odd up with wrap.
        load = 1'b1; data_in = 4'd3; mode = 1'b1;
        step_chk("odd_ld3", 4'd3);
        load = 1'b0;
        step_chk("odd_up5",  4'd5);
        step_chk("odd_up7",  4'd7);
        step_chk("odd_up9",  4'd9);
        step_chk("odd_up11", 4'd11);
        step_chk("odd_up13", 4'd13);
        step_chk("odd_up15", 4'd15);
        step_chk("odd_wrap1", 4'd1);
        step_chk("odd_up3",  4'd3);

        // Direction change from 7, effective next edge.
        load = 1'b1; data_in = 4'd7;
        step_chk("dir_ld7", 4'd7);
        load = 1'b0; mode = 1'b0;
        step_chk("dir_dn5",  4'd5);
        step_chk("dir_dn3",  4'd3);
        step_chk("dir_dn1",  4'd1);
        step_chk("dir_wrap15", 4'd15);
        step_chk("dir_dn13", 4'd13);

        // Even down after reset.
        rst = 1'b1;
        step_chk("ev_rst", 4'd0);
        rst = 1'b0; load = 1'b1; data_in = 4'd4; mode = 1'b0;
        step_chk("ev_ld4", 4'd4);
        load = 1'b0;
        step_chk("ev_dn2",  4'd2);
        step_chk("ev_dn0",  4'd0);
        step_chk("ev_wrap14", 4'd14);
        step_chk("ev_dn12", 4'd12);

        // Even up wrap 14 -> 0.
        load = 1'b1; data_in = 4'd14; mode = 1'b1;
        step_chk("evup_ld14", 4'd14);
        load = 1'b0;
        step_chk("evup_wrap0", 4'd0);
`else
        // Saturation: odd up, even down, even up at limit, then move away.
        load = 1'b1; data_in = 4'd13; mode = 1'b1;
        step_chk("sat_ld13", 4'd13);
        load = 1'b0;
        step_chk("sat_up15a", 4'd15);
        step_chk("sat_up15b", 4'd15);
        step_chk("sat_up15c", 4'd15);
        load = 1'b1; data_in = 4'd2; mode = 1'b0;
        step_chk("sat_ld2", 4'd2);
        load = 1'b0;
        step_chk("sat_dn0a", 4'd0);
        step_chk("sat_dn0b", 4'd0);
        load = 1'b1; data_in = 4'd14; mode = 1'b1;
        step_chk("sat_ld14", 4'd14);
        load = 1'b0;
        step_chk("sat_up14a", 4'd14);
        step_chk("sat_up14b", 4'd14);
        mode = 1'b0;
        step_chk("sat_away12", 4'd12);
        load = 1'b1; data_in = 4'd3;
        step_chk("sat_ld3", 4'd3);
        load = 1'b0;
        step_chk("sat_dn1a", 4'd1);
        step_chk("sat_dn1b", 4'd1);
`endif

        // Priority: reset beats load.
        rst = 1'b1; load = 1'b1; data_in = 4'd9; mode = 1'b1;
        step_chk("prio_rst", 4'd0);
        // Load beats count.
        rst = 1'b0;
        step_chk("prio_load", 4'd9);
        // Held load tracks data_in.
        data_in = 4'd10;
        step_chk("hold_ld10", 4'd10);
        data_in = 4'd5; mode = 1'b0;
        step_chk("hold_ld5", 4'd5);
        load = 1'b0; mode = 1'b1;
        step_chk("after_ld7", 4'd7);
        mode = 1'b0;
        step_chk("after_dn5", 4'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
